ascii_num_parser: RTL and testbench
===================================

ASCII_NUM_PARSER -- requirements
Module: ascii_num_parser

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports SHALL be named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 char_in  input  8  ASCII character byte.
REQ-005 char_valid  input  1  char_in holds a character this cycle.
REQ-006 char_ready  output  1  block accepts char_in this cycle; transfer = char_valid & char_ready.
REQ-007 value  output  16  parsed unsigned number.
REQ-008 ndigits  output  5  count of digits accepted for value, saturating at 31.
REQ-009 err  output  1  value is invalid: bad character or overflow.
REQ-010 value_valid  output  1  value, ndigits and err are stable and presentable.
REQ-011 value_ready  input  1  consumer takes result; transfer = value_valid & value_ready.

Function
REQ-012 Digit class: '0'..'9' (0x30..0x39) SHALL be decimal digits.
REQ-013 Terminator class: 0x20 space, 0x2D '-', 0x2E '.', 0x0A, 0x0D SHALL be terminators; every other byte is invalid.
REQ-014 States SHALL be IDLE, ZERO (single leading '0' seen), DEC, SKIP (invalid seen), OUT; HEX is added only under REQ-029.
REQ-015 IDLE: digit '0' -> ZERO; digit 1..9 -> DEC; terminator -> IDLE, no output; invalid -> SKIP.
REQ-016 ZERO/DEC: digit -> DEC, acc = acc*10 + d; terminator -> OUT; invalid -> SKIP.
REQ-017 SKIP: digits and invalid bytes SHALL be discarded; terminator -> OUT with value=0, err=1.
REQ-018 Arithmetic SHALL use a 20-bit intermediate; if the result exceeds 0xFFFF, acc saturates to 0xFFFF, an overflow flag is set, and parsing continues to the terminator; err = overflow flag.
REQ-019 value_valid SHALL rise in the cycle after the terminator transfer, giving 1-cycle latency, and hold with value, ndigits and err constant until value_ready.
REQ-020 In OUT, char_ready SHALL be 0; elsewhere char_ready SHALL be 1.
REQ-021 On the result transfer, the next state SHALL be IDLE with acc, ndigits and flags cleared, and char_ready rising in the following cycle; a char_valid asserted simultaneously with value_ready SHALL NOT be accepted that cycle.
REQ-022 ndigits SHALL count every accepted digit, including leading zeros, saturating at 31.

Reset
REQ-023 Reset SHALL force: state=IDLE, char_ready=0 during reset, value=0, ndigits=0, err=0, value_valid=0, internal acc and flags = 0.
REQ-024 Reset mid-number or in OUT SHALL discard the partial or pending result with no output.
REQ-025 char_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-026 Macro ASCII_HEX_EN SHALL compile hexadecimal support in or out.
REQ-027 Without ASCII_HEX_EN: 'x'/'X' and 'a'..'f'/'A'..'F' SHALL be invalid bytes, giving SKIP behaviour.
REQ-028 With ASCII_HEX_EN: in ZERO, 'x'/'X' -> HEX with acc=0 and ndigits unchanged.
REQ-029 HEX state: 0-9, a-f and A-F SHALL be digits, acc = acc*16 + d, overflow per REQ-018; terminator -> OUT; invalid -> SKIP; a terminator directly after "0x" SHALL give err=1, value=0.

Structure
REQ-030 Package ascii_pkg SHALL hold the state enum, character constants (terminators, '0', 'x', 'a', 'A'), and VALUE_W=16.
REQ-031 A combinational sub-module ascii_char_class SHALL map char_in to is_digit, is_hex, is_term, is_x and a 4-bit digit value.

Verification
REQ-032 "2023-" streamed back-to-back -> one result: value=2023 (0x07E7), ndigits=4, err=0, value_valid one cycle after '-'.
REQ-033 "65536 " -> value=0xFFFF, err=1, ndigits=5; "65535 " -> value=0xFFFF, err=0.
REQ-034 "PUC " -> value=0, err=1, ndigits=0; "   " alone -> no value_valid.
REQ-035 "12 34 " with value_ready held low for 5 cycles -> char_ready=0 throughout; value=12 held; on release, second result value=34.
REQ-036 Reset asserted after "99" with no terminator, then "7." -> a single result, value=7, ndigits=1.
REQ-037 With ASCII_HEX_EN: "0x4D " -> value=0x004D, err=0. Without ASCII_HEX_EN: "0x4D " -> value=0, err=1.

Source files
------------

// File: rtl/ascii_pkg.sv
// Shared states and character constants for the ASCII number parser.
// Defining ASCII_HEX_EN adds the HEX state for "0x" prefixed numbers.
package ascii_pkg;

   localparam int VALUE_W = 16;
   localparam int ACC_W   = VALUE_W + 4;
   localparam int CNT_W   = 5;

   localparam logic [7:0] CH_SP   = 8'h20;
   localparam logic [7:0] CH_DASH = 8'h2D;
   localparam logic [7:0] CH_DOT  = 8'h2E;
   localparam logic [7:0] CH_LF   = 8'h0A;
   localparam logic [7:0] CH_CR   = 8'h0D;
   localparam logic [7:0] CH_0    = 8'h30;
   localparam logic [7:0] CH_9    = 8'h39;
   localparam logic [7:0] CH_LX   = 8'h78;
   localparam logic [7:0] CH_UX   = 8'h58;
   localparam logic [7:0] CH_LA   = 8'h61;
   localparam logic [7:0] CH_UA   = 8'h41;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ZERO,
      ST_DEC,
      ST_SKIP,
      ST_OUT
`ifdef ASCII_HEX_EN
      , ST_HEX
`endif
   } state_e;

endpackage

// File: rtl/ascii_char_class.sv
// Combinational classifier: digit / hex digit / terminator / 'x' and
// the 4-bit value of a decimal or hex digit.
module ascii_char_class
   import ascii_pkg::*;
(
   input  logic [7:0] char_i,
   output logic       is_digit_o,
   output logic       is_hex_o,
   output logic       is_term_o,
   output logic       is_x_o,
   output logic [3:0] dval_o
);

   logic lower, upper;

   always_comb begin
      is_digit_o = (char_i >= CH_0) && (char_i <= CH_9);
      lower      = (char_i >= CH_LA) && (char_i <= CH_LA + 8'd5);
      upper      = (char_i >= CH_UA) && (char_i <= CH_UA + 8'd5);
      is_hex_o   = is_digit_o || lower || upper;
      is_term_o  = (char_i == CH_SP)  || (char_i == CH_DASH) ||
                   (char_i == CH_DOT) || (char_i == CH_LF)   ||
                   (char_i == CH_CR);
      is_x_o     = (char_i == CH_LX) || (char_i == CH_UX);
      dval_o     = '0;
      if (is_digit_o)
         dval_o = 4'(char_i - CH_0);
      else if (lower)
         dval_o = 4'(char_i - CH_LA + 8'd10);
      else if (upper)
         dval_o = 4'(char_i - CH_UA + 8'd10);
   end

endmodule

// File: rtl/ascii_num_parser.sv
// Streams ASCII bytes and emits one unsigned 16-bit number per terminated
// token, with digit count and an error flag. ASCII_HEX_EN enables "0x" hex.
module ascii_num_parser
   import ascii_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         char_in,
   input  logic               char_valid,
   output logic               char_ready,
   output logic [VALUE_W-1:0] value,
   output logic [CNT_W-1:0]   ndigits,
   output logic               err,
   output logic               value_valid,
   input  logic               value_ready
);

   state_e             state_q;
   logic [VALUE_W-1:0] acc_q, acc_d, value_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d, ndig_q;
   logic               ovf_q, err_q, vld_q;
   logic               c_dig, c_hex, c_term, c_x;
   logic               sat, xfer;
   logic [3:0]         dval;
   logic [ACC_W-1:0]   base, sum;

`ifdef ASCII_HEX_EN
   logic               hexd_q;
`else
   logic               unused_cls;
   assign unused_cls = c_hex | c_x;
`endif

   ascii_char_class u_cls (
      .char_i     (char_in),
      .is_digit_o (c_dig),
      .is_hex_o   (c_hex),
      .is_term_o  (c_term),
      .is_x_o     (c_x),
      .dval_o     (dval)
   );

   assign char_ready  = !reset && (state_q != ST_OUT);
   assign xfer        = char_valid && char_ready;
   assign value       = value_q;
   assign ndigits     = ndig_q;
   assign err         = err_q;
   assign value_valid = vld_q;

   // Widened accumulate so a single step can never wrap before saturating.
   always_comb begin
      base = ACC_W'(acc_q) * ACC_W'(10);
`ifdef ASCII_HEX_EN
      if (state_q == ST_HEX)
         base = {acc_q, 4'd0};
`endif
      sum   = base + ACC_W'(dval);
      sat   = sum > ACC_W'({VALUE_W{1'b1}});
      acc_d = sat ? '1 : sum[VALUE_W-1:0];
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 5'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         value_q <= '0;
         ndig_q  <= '0;
         err_q   <= 1'b0;
         vld_q   <= 1'b0;
`ifdef ASCII_HEX_EN
         hexd_q  <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE: if (xfer) begin
               if (c_dig) begin
                  acc_q   <= acc_d;
                  cnt_q   <= cnt_d;
                  state_q <= (dval == 4'd0) ? ST_ZERO : ST_DEC;
               end else if (!c_term) begin
                  state_q <= ST_SKIP;
               end
            end
            ST_ZERO, ST_DEC: if (xfer) begin
               if (c_dig) begin
                  acc_q   <= acc_d;
                  ovf_q   <= ovf_q | sat;
                  cnt_q   <= cnt_d;
                  state_q <= ST_DEC;
`ifdef ASCII_HEX_EN
               end else if (state_q == ST_ZERO && c_x) begin
                  acc_q   <= '0;
                  state_q <= ST_HEX;
`endif
               end else if (c_term) begin
                  value_q <= acc_q;
                  ndig_q  <= cnt_q;
                  err_q   <= ovf_q;
                  vld_q   <= 1'b1;
                  state_q <= ST_OUT;
               end else begin
                  state_q <= ST_SKIP;
               end
            end
`ifdef ASCII_HEX_EN
            ST_HEX: if (xfer) begin
               if (c_hex) begin
                  acc_q   <= acc_d;
                  ovf_q   <= ovf_q | sat;
                  cnt_q   <= cnt_d;
                  hexd_q  <= 1'b1;
               end else if (c_term) begin
                  // A bare "0x" has no digits and is reported as an error.
                  value_q <= hexd_q ? acc_q : '0;
                  ndig_q  <= cnt_q;
                  err_q   <= ovf_q | !hexd_q;
                  vld_q   <= 1'b1;
                  state_q <= ST_OUT;
               end else begin
                  state_q <= ST_SKIP;
               end
            end
`endif
            ST_SKIP: if (xfer && c_term) begin
               value_q <= '0;
               ndig_q  <= cnt_q;
               err_q   <= 1'b1;
               vld_q   <= 1'b1;
               state_q <= ST_OUT;
            end
            ST_OUT: if (value_ready) begin
               vld_q   <= 1'b0;
               acc_q   <= '0;
               cnt_q   <= '0;
               ovf_q   <= 1'b0;
`ifdef ASCII_HEX_EN
               hexd_q  <= 1'b0;
`endif
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ascii_num_parser.sv
// Randomized token streams checked against a string-level reference model,
// plus directed cases for latency, saturation, backpressure and reset.
module tb_ascii_num_parser;

   typedef struct packed {
      logic [15:0] v;
      logic [4:0]  nd;
      logic        e;
   } res_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  char_in;
   logic        char_valid;
   logic        char_ready;
   logic [15:0] value;
   logic [4:0]  ndigits;
   logic        err;
   logic        value_valid;
   logic        value_ready;

   int   checks = 0;
   int   errors = 0;
   int   extra  = 0;
   int   rdy_mode = 0;
   bit   busy = 0;
   res_t expq[$];

   logic [7:0] terms[5] = '{8'h20, 8'h2D, 8'h2E, 8'h0A, 8'h0D};
   logic [7:0] hexl[6]  = '{8'h61, 8'h66, 8'h41, 8'h46, 8'h63, 8'h44};
   logic [7:0] badc[5]  = '{8'h50, 8'h78, 8'h23, 8'h5A, 8'h40};

   ascii_num_parser dut (
      .clk         (clk),
      .reset       (reset),
      .char_in     (char_in),
      .char_valid  (char_valid),
      .char_ready  (char_ready),
      .value       (value),
      .ndigits     (ndigits),
      .err         (err),
      .value_valid (value_valid),
      .value_ready (value_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int digit_of(input logic [7:0] c, input bit hex);
      if (c >= 8'h30 && c <= 8'h39) return int'(c - 8'h30);
      if (hex && c >= 8'h61 && c <= 8'h66) return int'(c - 8'h61) + 10;
      if (hex && c >= 8'h41 && c <= 8'h46) return int'(c - 8'h41) + 10;
      return -1;
   endfunction

   // Token = bytes between terminators; returns 0 when nothing is emitted.
   function automatic bit model(input string t, output res_t r);
      longint acc = 0;
      bit ovf = 0, bad = 0, hex = 0;
      int digs = 0, st = 0, d;
      r = '0;
      if (t.len() == 0) return 0;
`ifdef ASCII_HEX_EN
      if (t.len() >= 2 && t[0] == 8'h30 && (t[1] == 8'h78 || t[1] == 8'h58)) begin
         hex = 1; digs = 1; st = 2;
      end
`endif
      for (int i = st; i < t.len() && !bad; i++) begin
         d = digit_of(t[i], hex);
         if (d < 0) bad = 1;
         else begin
            acc = acc * (hex ? 16 : 10) + d;
            if (acc > 65535) begin acc = 65535; ovf = 1; end
            digs++;
         end
      end
      r.nd = (digs > 31) ? 5'd31 : 5'(digs);
      if (bad || (hex && t.len() == 2)) begin
         r.v = '0; r.e = 1'b1;
      end else begin
         r.v = 16'(acc); r.e = ovf;
      end
      return 1;
   endfunction

   function automatic string gen_tok();
      string t = "";
      int n, r;
      logic [7:0] c;
      n = ($urandom_range(0, 14) == 0) ? $urandom_range(28, 36) : $urandom_range(0, 6);
`ifdef ASCII_HEX_EN
      if ($urandom_range(0, 3) == 0) t = $urandom_range(0, 1) ? "0x" : "0X";
`endif
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 99);
         if (r < 78) c = 8'h30 + 8'($urandom_range(0, 9));
         else if (r < 90) c = hexl[$urandom_range(0, 5)];
         else c = badc[$urandom_range(0, 4)];
         t = $sformatf("%s%c", t, c);
      end
      return t;
   endfunction

   task automatic send_str(input string s, input bit gaps);
      int g;
      busy = 1;
      for (int i = 0; i < s.len(); i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin
            @(negedge clk); char_valid = 1'b0;
         end
         @(negedge clk);
         char_valid = 1'b1;
         char_in    = s[i];
         g = 0;
         while (!char_ready && g < 500) begin @(negedge clk); g++; end
         if (g >= 500) begin
            chk("send_timeout", 0, 1);
            break;
         end
      end
      @(negedge clk);
      char_valid = 1'b0;
      busy = 0;
   endtask

   task automatic push(input logic [15:0] v, input logic [4:0] nd, input logic e);
      res_t r;
      r.v = v; r.nd = nd; r.e = e;
      expq.push_back(r);
   endtask

   task automatic wait_valid(input int lim);
      int n = 0;
      while (!value_valid && n < lim) begin @(negedge clk); n++; end
      chk("wait_valid", value_valid, 1);
   endtask

   task automatic drain();
      int n = 0;
      while ((busy || expq.size() != 0 || value_valid) && n < 2000) begin
         @(negedge clk); n++;
      end
      chk("drain", expq.size(), 0);
   endtask

   // Result side: compare each new result once, then drive value_ready.
   initial begin
      bit seen = 0, was_extra = 0;
      value_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            seen = 0; value_ready = 1'b0;
            continue;
         end
         if (value_valid && !seen) begin
            seen = 1;
            was_extra = (expq.size() == 0);
            if (was_extra) begin
               extra++;
            end else begin
               chk("value",   value,   expq[0].v);
               chk("ndigits", ndigits, expq[0].nd);
               chk("err",     err,     expq[0].e);
            end
         end
         case (rdy_mode)
            0: value_ready = ($urandom_range(0, 2) != 0);
            1: value_ready = 1'b0;
            default: value_ready = 1'b1;
         endcase
         if (value_valid && value_ready) begin
            if (!was_extra && expq.size() != 0) void'(expq.pop_front());
            seen = 0; was_extra = 0;
         end
      end
   end

   initial begin
      res_t r;
      string s, tok;
      reset = 1'b1; char_valid = 1'b0; char_in = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_value", value, 0);
      chk("rst_ndigits", ndigits, 0);
      chk("rst_err", err, 0);
      chk("rst_valid", value_valid, 0);
      chk("rst_ready", char_ready, 0);
      reset = 1'b0;
      #1 chk("ready_after_rst", char_ready, 1);

      rdy_mode = 2;
      push(16'd2023, 5'd4, 1'b0);
      send_str("2023-", 0);
      chk("latency", value_valid, 1);
      drain();

      push(16'hFFFF, 5'd5, 1'b1);
      push(16'hFFFF, 5'd5, 1'b0);
      push(16'h0000, 5'd0, 1'b1);
      send_str("65536 65535 PUC    ", 1);
      drain();

      s = "";
      for (int i = 0; i < 33; i++) s = {s, "0"};
      push(16'h0000, 5'd31, 1'b0);
      send_str({s, "."}, 0);
      drain();

`ifdef ASCII_HEX_EN
      push(16'h004D, 5'd3, 1'b0);
      push(16'h0000, 5'd1, 1'b1);
      send_str("0x4D 0x ", 0);
`else
      push(16'h0000, 5'd1, 1'b1);
      send_str("0x4D ", 0);
`endif
      drain();

      rdy_mode = 1;
      push(16'd12, 5'd2, 1'b0);
      push(16'd34, 5'd2, 1'b0);
      fork
         send_str("12 34 ", 0);
      join_none
      #1;
      wait_valid(50);
      repeat (5) begin
         @(negedge clk);
         chk("hold_ready", char_ready, 0);
         chk("hold_value", value, 12);
      end
      rdy_mode = 2;
      drain();

      send_str("99", 0);
      reset = 1'b1;
      #1 chk("rst_mid_ready", char_ready, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1 chk("rst_mid_ready1", char_ready, 1);
      push(16'd7, 5'd1, 1'b0);
      send_str("7.", 0);
      drain();

      rdy_mode = 0;
      repeat (80) begin
         tok = gen_tok();
         if (model(tok, r)) expq.push_back(r);
         send_str($sformatf("%s%c", tok, terms[$urandom_range(0, 4)]), 1);
      end
      drain();

      chk("extra_results", extra, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
